// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Front-end instruction fetch sequencer. Issues one 32-bit
//               fetch at a time, latches the returned word with its PC and
//               offers it to the decoder on a valid/ready handshake. Handles
//               redirects (possibly draining an in-flight fetch), halt and
//               sticky fetch faults.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    input  logic              mem_resp_err,

    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,

    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_req   = 3'd0;  // ready to issue a fetch
    localparam logic [2:0] c_st_wait  = 3'd1;  // fetch accepted, awaiting response
    localparam logic [2:0] c_st_drain = 3'd2;  // awaiting a response to throw away
    localparam logic [2:0] c_st_hold  = 3'd3;  // presenting a word to the decoder
    localparam logic [2:0] c_st_fault = 3'd4;  // parked until redirect or reset

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instruction;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_pc;

    // Next-state values
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       w_instruction_nxt;
    logic [ADDR_W-1:0] w_instr_pc_nxt;
    logic              w_fault_nxt;
    logic [ADDR_W-1:0] w_fault_pc_nxt;

    // ------------------------------------------------------------------------
    // Request side / helper terms
    // ------------------------------------------------------------------------
    logic w_req_valid;
    logic w_req_fire;
    logic w_misaligned;
    logic w_busy_after;

    assign w_req_valid  = (r_state == c_st_req) && !halt;
    assign w_req_fire   = w_req_valid && mem_req_ready;
    assign w_misaligned = |redirect_pc[1:0];

    // A response is still owed to us after this cycle if a fetch is in flight
    // and its response does not land now, or if a fetch is accepted now.
    // A response landing in the same cycle as a redirect (WAIT or DRAIN) has
    // been consumed, so there is nothing left to drain.
    assign w_busy_after = (((r_state == c_st_wait) || (r_state == c_st_drain)) && !mem_resp_valid)
                        || ((r_state == c_st_req) && w_req_fire);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_pc;
    assign instruction   = r_instruction;
    assign instr_pc      = r_instr_pc;
    assign instr_valid   = (r_state == c_st_hold);
    assign fault         = r_fault;
    assign fault_pc      = r_fault_pc;

    // Next-state and datapath decode; redirect overrides every other event
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instruction_nxt = r_instruction;
        w_instr_pc_nxt    = r_instr_pc;
        w_fault_nxt       = r_fault;
        w_fault_pc_nxt    = r_fault_pc;

        if (redirect_valid) begin
            w_pc_nxt    = redirect_pc;
            w_fault_nxt = w_misaligned;
            if (w_misaligned) begin
                w_fault_pc_nxt = redirect_pc;
            end
            // A misaligned target never reaches the bus: DRAIN hands over to
            // FAULT afterwards because the fault flag is already set.
            if (w_busy_after) begin
                w_state_nxt = c_st_drain;
            end else if (w_misaligned) begin
                w_state_nxt = c_st_fault;
            end else begin
                w_state_nxt = c_st_req;
            end
        end else begin
            case (r_state)
                c_st_req: begin
                    if (w_req_fire) begin
                        w_state_nxt = c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            w_fault_nxt    = 1'b1;
                            w_fault_pc_nxt = r_pc;
                            w_state_nxt    = c_st_fault;
                        end else begin
                            w_instruction_nxt = mem_resp_data;
                            w_instr_pc_nxt    = r_pc;
                            w_pc_nxt          = r_pc + c_pc_step;
                            w_state_nxt       = c_st_hold;
                        end
                    end
                end
                c_st_drain: begin
                    // Data and error of the drained response are discarded.
                    // A set fault flag here means a misaligned redirect is pending.
                    if (mem_resp_valid) begin
                        w_state_nxt = r_fault ? c_st_fault : c_st_req;
                    end
                end
                c_st_hold: begin
                    if (instr_ready) begin
                        w_state_nxt = c_st_req;
                    end
                end
                c_st_fault: begin
                    w_state_nxt = c_st_fault;
                end
                default: begin
                    w_state_nxt = c_st_req;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_req;
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_instr_pc    <= '0;
            r_fault       <= 1'b0;
            r_fault_pc    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instruction <= w_instruction_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_pc    <= w_fault_pc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Self-checking bench for fetch_controller. A memory responder
//               and a flag-based behavioural model of the fetch sequence run
//               alongside the DUT; outputs are compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam logic [63:0] C_RESET_PC = 64'h1000;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [63:0] fault_pc;

    fetch_controller #(
        .ADDR_W   (64),
        .RESET_PC (C_RESET_PC)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory responder: one outstanding fetch, fixed latency per fetch
    int          cfg_lat  = 1;
    logic [31:0] cfg_data = 32'h0;
    logic        cfg_err  = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_data = 32'h0;
    logic        mem_err  = 1'b0;
    logic        last_accept = 1'b0;

    // Behavioural model: pc, "fetch outstanding", "outstanding will be
    // discarded", "word on offer", plus latched output values
    logic [63:0] m_pc;
    logic        m_out;
    logic        m_disc;
    logic        m_hold;
    logic        m_fault;
    logic [31:0] m_instr;
    logic [63:0] m_ipc;
    logic [63:0] m_fpc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = C_RESET_PC;
        m_out   = 1'b0;
        m_disc  = 1'b0;
        m_hold  = 1'b0;
        m_fault = 1'b0;
        m_instr = 32'h0;
        m_ipc   = 64'h0;
        m_fpc   = 64'h0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // then advance memory and model to the next cycle.
    task automatic cycle(input logic t_rst, input logic t_halt, input logic t_ready,
                         input logic t_redir, input logic [63:0] t_rpc,
                         input logic t_ir, input logic t_spur);
        logic exp_req;
        logic acc_model;
        logic mis;
        logic keep_out;
        @(negedge clk);
        rst            = t_rst;
        halt           = t_halt;
        mem_req_ready  = t_ready && !mem_busy;
        redirect_valid = t_redir;
        redirect_pc    = t_rpc;
        instr_ready    = t_ir;
        if (mem_busy && mem_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_data;
            mem_resp_err   = mem_err;
        end else if (t_spur && !mem_busy) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            mem_resp_err   = 1'($urandom_range(0, 1));
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            mem_resp_err   = 1'($urandom_range(0, 1));
        end
        #1;
        exp_req = !m_out && !m_hold && !m_fault && !t_halt;
        check("req_valid",   mem_req_valid, exp_req);
        check("req_addr",    mem_req_addr,  m_pc);
        check("instr_valid", instr_valid,   m_hold);
        check("instruction", instruction,   m_instr);
        check("instr_pc",    instr_pc,      m_ipc);
        check("fault",       fault,         m_fault);
        check("fault_pc",    fault_pc,      m_fpc);

        // memory side
        last_accept = mem_req_valid && mem_req_ready;
        if (mem_busy && mem_cnt == 0) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (last_accept) begin
            mem_busy = 1'b1;
            mem_cnt  = cfg_lat - 1;
            mem_data = cfg_data;
            mem_err  = cfg_err;
        end

        // model side
        acc_model = exp_req && mem_req_ready;
        if (t_rst) begin
            model_reset();
        end else if (t_redir) begin
            mis      = (t_rpc[1:0] != 2'b00);
            keep_out = (m_out && !mem_resp_valid) || acc_model;
            m_pc     = t_rpc;
            m_hold   = 1'b0;
            m_fault  = mis;
            if (mis) m_fpc = t_rpc;
            m_out    = keep_out;
            m_disc   = keep_out;
        end else if (m_out && mem_resp_valid) begin
            m_out = 1'b0;
            if (m_disc) begin
                m_disc = 1'b0;
            end else if (mem_resp_err) begin
                m_fault = 1'b1;
                m_fpc   = m_pc;
            end else begin
                m_instr = mem_resp_data;
                m_ipc   = m_pc;
                m_pc    = m_pc + 64'd4;
                m_hold  = 1'b1;
            end
        end else if (acc_model) begin
            m_out  = 1'b1;
            m_disc = 1'b0;
        end else if (m_hold && t_ir) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic redirect(input logic [63:0] pc, input logic ready);
        cycle(1'b0, 1'b0, ready, 1'b1, pc, 1'b1, 1'b0);
    endtask

    task automatic run_until_valid(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (instr_valid) break;
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        end
        check(tag, instr_valid, 1'b1);
    endtask

    task automatic run_until_accept(input string tag);
        last_accept = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
            if (last_accept) break;
        end
        check(tag, last_accept, 1'b1);
    endtask

    // Safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; halt = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0; mem_resp_err = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 64'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // streaming fetch with 1-cycle memory
        cfg_lat = 1; cfg_data = 32'h20011410; cfg_err = 1'b0;
        idle(9);
        check("t1_next_addr", mem_req_addr, 64'h100c);
        check("t1_last_pc", instr_pc, 64'h1008);

        // back-pressure from the decoder
        cfg_data = 32'h5432FF13;
        run_until_valid("t2_valid");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        check("t2_instr", instruction, 64'h5432FF13);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        check("t2_req_after", mem_req_valid, 1'b1);

        // redirect while waiting: late response must be dropped
        cfg_lat = 3; cfg_data = 32'h00000401;
        run_until_accept("t3_accept");
        redirect(64'h2000, 1'b1);
        idle(2);
        check("t3_req", mem_req_valid, 1'b1);
        check("t3_addr", mem_req_addr, 64'h2000);

        // redirect coinciding with acceptance in HOLD
        cfg_lat = 1;
        run_until_valid("t4_valid");
        redirect(64'h3000, 1'b1);
        check("t4_valid_drop", instr_valid, 1'b0);
        check("t4_addr", mem_req_addr, 64'h3000);

        // bus error on the fetch at 0x1004
        redirect(64'h1000, 1'b0);
        run_until_valid("t5_valid");
        cfg_err = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        cfg_err = 1'b0;
        check("t5_fault", fault, 1'b1);
        check("t5_fault_pc", fault_pc, 64'h1004);
        idle(10);
        redirect(64'h4000, 1'b1);
        check("t5_fault_clr", fault, 1'b0);
        check("t5_addr", mem_req_addr, 64'h4000);

        // misaligned redirect with nothing outstanding
        redirect(64'h4002, 1'b0);
        check("t6_fault_pc", fault_pc, 64'h4002);
        idle(3);
        check("t6_no_req", mem_req_valid, 1'b0);

        // misaligned redirect with a fetch in flight: drain, then fault
        redirect(64'h5000, 1'b0);
        cfg_lat = 3;
        run_until_accept("t6b_accept");
        redirect(64'h6001, 1'b1);
        idle(4);
        check("t6b_fault", fault, 1'b1);
        check("t6b_no_req", mem_req_valid, 1'b0);

        // halt in REQ
        redirect(64'h5000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
            check("t7_halt", mem_req_valid, 1'b0);
        end
        idle(2);

        // reset while waiting; late response must be ignored
        cfg_lat = 4;
        redirect(64'h7000, 1'b0);
        run_until_accept("t8_accept");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        check("t8_addr", mem_req_addr, C_RESET_PC);
        check("t8_instr", instruction, 64'h0);
        idle(8);

        // PC wraps at the top of the address space
        cfg_lat = 1;
        redirect(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        run_until_valid("t9_valid");
        check("t9_wrap", mem_req_addr, 64'h0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rpc;
            int sel;
            cfg_lat  = $urandom_range(1, 4);
            cfg_data = $urandom;
            cfg_err  = ($urandom_range(0, 14) == 0);
            rpc      = {$urandom, $urandom};
            sel      = $urandom_range(0, 9);
            if (sel == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            else if (sel == 1) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            else rpc[1:0] = 2'b00;
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0),
                  rpc,
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
